// File: rtl/rvv_backend_alu_unit_mask_viota_seq.sv
// Sequential viota.m engine: streams exclusive prefix-popcounts CHUNK elements per beat.
// Optional build macro VIOTA_SEQ_CPOP_EN adds the out_cpop total-count port for vcpop.m.
module rvv_backend_alu_unit_mask_viota_seq #(
  parameter int VLEN  = 128,
  parameter int CHUNK = 32,
  parameter int OUT_W = $clog2(VLEN) + 1,
  localparam int NCHUNK = VLEN / CHUNK,
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  localparam int VL_W   = $clog2(VLEN) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [VLEN-1:0]        src_mask,
  input  logic [VLEN-1:0]        src_vm,
  input  logic [VL_W-1:0]        src_vl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHUNK*OUT_W-1:0] out_data,
  output logic [CHUNK-1:0]       out_en,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
`ifdef VIOTA_SEQ_CPOP_EN
  output logic [OUT_W-1:0]       out_cpop,
`endif
  output logic [0:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // once out_valid is raised every out_* signal holds until that transfer.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int CSH = $clog2(CHUNK);

  logic [0:0]       state;
  logic [VLEN-1:0]  eff_mask;
  logic [VLEN-1:0]  act_mask;
  logic [IDX_W-1:0] chunk;
  logic [IDX_W-1:0] last_chunk;
  // Count of effective bits up to and including the chunk currently on the output.
  logic [OUT_W-1:0] run_cnt;

  logic accept;
  logic hs;

  assign src_ready = (state == ST_IDLE);
  assign accept    = src_ready & src_valid;
  assign hs        = out_valid & out_ready;
  assign dbg_state = state;

  logic [VLEN-1:0]  in_rng;
  logic [VLEN-1:0]  new_act;
  logic [VLEN-1:0]  new_eff;
  logic [IDX_W-1:0] new_last;

  always_comb begin
    in_rng = '0;
    for (int i = 0; i < VLEN; i++) begin
      in_rng[i] = (i < int'(src_vl));
    end
    new_act  = src_vm & in_rng;
    new_eff  = src_mask & new_act;
    new_last = '0;
    if (src_vl != '0) begin
      new_last = IDX_W'((src_vl - 1'b1) >> CSH);
    end
  end

  // Next beat: chunk 0 of the incoming request when idle, otherwise chunk+1 seeded by run_cnt.
  logic [IDX_W-1:0]       sel_idx;
  logic [CHUNK-1:0]       sel_bits;
  logic [CHUNK-1:0]       sel_en;
  logic                   sel_last;
  logic [VLEN-1:0]        sh_eff;
  logic [VLEN-1:0]        sh_act;
  logic [CHUNK*OUT_W-1:0] beat_data;
  logic [OUT_W-1:0]       acc;

  always_comb begin
    sel_idx   = '0;
    sel_bits  = '0;
    sel_en    = '0;
    sel_last  = 1'b0;
    sh_eff    = '0;
    sh_act    = '0;
    beat_data = '0;
    acc       = '0;
    if (state == ST_IDLE) begin
      sel_bits = new_eff[CHUNK-1:0];
      sel_en   = new_act[CHUNK-1:0];
      sel_last = (new_last == '0);
    end else begin
      sel_idx  = chunk + 1'b1;
      sh_eff   = eff_mask >> {sel_idx, {CSH{1'b0}}};
      sh_act   = act_mask >> {sel_idx, {CSH{1'b0}}};
      sel_bits = sh_eff[CHUNK-1:0];
      sel_en   = sh_act[CHUNK-1:0];
      sel_last = (sel_idx == last_chunk);
      acc      = run_cnt;
    end
    for (int j = 0; j < CHUNK; j++) begin
      beat_data[j*OUT_W +: OUT_W] = acc;
      acc = acc + OUT_W'(sel_bits[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      eff_mask   <= '0;
      act_mask   <= '0;
      chunk      <= '0;
      last_chunk <= '0;
      run_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_en     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
`ifdef VIOTA_SEQ_CPOP_EN
      out_cpop   <= '0;
`endif
    end else if (accept) begin
      state      <= ST_RUN;
      eff_mask   <= new_eff;
      act_mask   <= new_act;
      last_chunk <= new_last;
      chunk      <= '0;
      run_cnt    <= acc;
      out_valid  <= 1'b1;
      out_data   <= beat_data;
      out_en     <= sel_en;
      out_idx    <= sel_idx;
      out_last   <= sel_last;
`ifdef VIOTA_SEQ_CPOP_EN
      out_cpop   <= sel_last ? acc : '0;
`endif
    end else if (hs) begin
      if (out_last) begin
        state     <= ST_IDLE;
        chunk     <= '0;
        run_cnt   <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_en    <= '0;
        out_idx   <= '0;
        out_last  <= 1'b0;
`ifdef VIOTA_SEQ_CPOP_EN
        out_cpop  <= '0;
`endif
      end else begin
        chunk    <= sel_idx;
        run_cnt  <= acc;
        out_data <= beat_data;
        out_en   <= sel_en;
        out_idx  <= sel_idx;
        out_last <= sel_last;
`ifdef VIOTA_SEQ_CPOP_EN
        out_cpop <= sel_last ? acc : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_alu_unit_mask_viota_seq.sv
// Bench for the sequential viota.m engine: directed requests, expected-beat queue, negedge monitor.
`timescale 1ns/1ps
module tb_rvv_backend_alu_unit_mask_viota_seq;

  localparam int VLEN   = 128;
  localparam int CHUNK  = 32;
  localparam int OUT_W  = $clog2(VLEN) + 1;
  localparam int NCHUNK = VLEN / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int VL_W   = $clog2(VLEN) + 1;
  localparam int CW     = CHUNK * OUT_W;
  localparam int EW     = CW + CHUNK + IDX_W + 1 + OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                src_valid;
  logic                src_ready;
  logic [VLEN-1:0]     src_mask;
  logic [VLEN-1:0]     src_vm;
  logic [VL_W-1:0]     src_vl;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_data;
  logic [CHUNK-1:0]    out_en;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;
  logic [0:0]          dbg_state;
`ifdef VIOTA_SEQ_CPOP_EN
  logic [OUT_W-1:0]    out_cpop;
`endif

  rvv_backend_alu_unit_mask_viota_seq #(.VLEN(VLEN), .CHUNK(CHUNK), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_mask  (src_mask),
    .src_vm    (src_vm),
    .src_vl    (src_vl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_en    (out_en),
    .out_idx   (out_idx),
    .out_last  (out_last),
`ifdef VIOTA_SEQ_CPOP_EN
    .out_cpop  (out_cpop),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CW-1:0]    rx_data[$];
  logic [CHUNK-1:0] rx_en[$];
  int               rx_cyc[$];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: element n counts effective bits strictly below n, recounted from scratch.
  function automatic void push_expected(input logic [VLEN-1:0] m, input logic [VLEN-1:0] vm,
                                        input int vl);
    logic [VLEN-1:0]  live;
    logic [CW-1:0]    d;
    logic [CHUNK-1:0] e;
    logic [OUT_W-1:0] cp;
    int nb;
    int total;
    int n;
    int cnt;
    nb    = (vl == 0) ? 1 : (vl + CHUNK - 1) / CHUNK;
    total = 0;
    live  = '0;
    for (int i = 0; i < VLEN; i++) begin
      live[i] = m[i] & vm[i] & (i < vl);
      if (live[i]) total++;
    end
    for (int k = 0; k < nb; k++) begin
      d = '0;
      e = '0;
      for (int j = 0; j < CHUNK; j++) begin
        n   = k * CHUNK + j;
        cnt = 0;
        for (int i = 0; i < n; i++) if (live[i]) cnt++;
        d[j*OUT_W +: OUT_W] = OUT_W'(cnt);
        e[j] = vm[n] && (n < vl);
      end
      cp = '0;
`ifdef VIOTA_SEQ_CPOP_EN
      if (k == nb - 1) cp = OUT_W'(total);
`endif
      exp_q.push_back({d, e, IDX_W'(k), (k == nb - 1), cp});
    end
  endfunction

  // ---------------- monitor ----------------
  logic [EW-1:0]    ex;
  logic             stalled = 1'b0;
  logic [CW-1:0]    held_data;
  logic [CHUNK-1:0] held_en;
  logic [IDX_W-1:0] held_idx;
  logic             held_last;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      chk("src_ready_low_in_run", CW'(src_ready), CW'(0));
      if (stalled) begin
        chk("stall_data", out_data, held_data);
        chk("stall_en", CW'(out_en), CW'(held_en));
        chk("stall_idx", CW'(out_idx), CW'(held_idx));
        chk("stall_last", CW'(out_last), CW'(held_last));
      end
      if (out_ready) begin
        stalled = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
        end else begin
          ex = exp_q.pop_front();
          chk("beat_data", out_data, ex[EW-1 -: CW]);
          chk("beat_en", CW'(out_en), CW'(ex[OUT_W+1+IDX_W +: CHUNK]));
          chk("beat_idx", CW'(out_idx), CW'(ex[OUT_W+1 +: IDX_W]));
          chk("beat_last", CW'(out_last), CW'(ex[OUT_W]));
`ifdef VIOTA_SEQ_CPOP_EN
          chk("beat_cpop", CW'(out_cpop), CW'(ex[OUT_W-1:0]));
`endif
        end
        rx_data.push_back(out_data);
        rx_en.push_back(out_en);
        rx_cyc.push_back(cyc);
      end else begin
        stalled   = 1'b1;
        held_data = out_data;
        held_en   = out_en;
        held_idx  = out_idx;
        held_last = out_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_clear();
    rx_data.delete();
    rx_en.delete();
    rx_cyc.delete();
  endtask

  task automatic send(input logic [VLEN-1:0] m, input logic [VLEN-1:0] vm, input int vl);
    int g;
    g = 0;
    while (src_ready !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("src_ready_wait", CW'(src_ready), CW'(1));
    push_expected(m, vm, vl);
    src_mask  = m;
    src_vm    = vm;
    src_vl    = VL_W'(vl);
    src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    src_mask  = {$urandom(), $urandom(), $urandom(), $urandom()};
    src_vm    = {$urandom(), $urandom(), $urandom(), $urandom()};
    src_vl    = VL_W'($urandom_range(0, VLEN));
    chk("beat0_latency", CW'(out_valid), CW'(1));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("src_ready_after_last", CW'(src_ready), CW'(1));
  endtask

  function automatic logic [OUT_W-1:0] rx_elem(input int b, input int j);
    logic [CW-1:0] t;
    if (b >= rx_data.size()) return '1;
    t = rx_data[b];
    return t[j*OUT_W +: OUT_W];
  endfunction

  // ---------------- stimulus ----------------
  logic [VLEN-1:0] all1;
  logic [VLEN-1:0] aa;
  logic [VLEN-1:0] v55;
  logic [VLEN-1:0] one;
  logic [VLEN-1:0] rnd_m;
  logic [VLEN-1:0] rnd_v;

  initial begin
    all1 = '1;
    aa   = {32{4'hA}};
    v55  = {32{4'h5}};
    one  = VLEN'(1);
    rst = 1'b1; src_valid = 1'b0; src_mask = '0; src_vm = '0; src_vl = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_ready", CW'(src_ready), CW'(1));
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_out_data", out_data, CW'(0));
    chk("rst_out_en", CW'(out_en), CW'(0));
    chk("rst_out_idx", CW'(out_idx), CW'(0));
    chk("rst_out_last", CW'(out_last), CW'(0));
    chk("rst_state", CW'(dbg_state), CW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // All ones, full length, back-to-back
    rx_clear();
    send(all1, all1, 128);
    drain();
    chk("t1_beats", CW'(rx_data.size()), CW'(4));
    chk("t1_b1e0", CW'(rx_elem(1, 0)), CW'(32));
    chk("t1_b3e31", CW'(rx_elem(3, 31)), CW'(127));
    if (rx_cyc.size() == 4) chk("t1_back_to_back", CW'(rx_cyc[3] - rx_cyc[0]), CW'(3));

    // Alternating mask, vl=70
    rx_clear();
    send(aa, all1, 70);
    drain();
    chk("t2_beats", CW'(rx_data.size()), CW'(3));
    chk("t2_b1e0", CW'(rx_elem(1, 0)), CW'(16));
    chk("t2_b2e5", CW'(rx_elem(2, 5)), CW'(34));
    if (rx_en.size() == 3) chk("t2_b2_en", CW'(rx_en[2]), CW'(32'h3F));

    // vl = 0: single empty beat
    rx_clear();
    send(all1, all1, 0);
    drain();
    chk("t3_beats", CW'(rx_data.size()), CW'(1));
    if (rx_en.size() == 1) begin
      chk("t3_en", CW'(rx_en[0]), CW'(0));
      chk("t3_data", rx_data[0], CW'(0));
    end

    // Execution mask gates counting
    rx_clear();
    send(all1, v55, 128);
    drain();
    chk("t4_b3e0", CW'(rx_elem(3, 0)), CW'(48));

    // Chunk boundary lengths
    rnd_m = {$urandom(), $urandom(), $urandom(), $urandom()};
    rnd_v = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(rnd_m, rnd_v, 32);
    drain();
    send(rnd_m, rnd_v, 33);
    drain();
    send(rnd_m, all1, 127);
    drain();

    // Backpressure on beat 1, with a stray request attempt during RUN
    rx_clear();
    send(aa, all1, 128);
    @(posedge clk); #1;
    out_ready = 1'b0;
    src_valid = 1'b1;
    src_mask  = all1;
    src_vl    = VL_W'(5);
    repeat (5) begin
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t5_beats", CW'(rx_data.size()), CW'(4));

    // Reset mid-request
    send(all1, all1, 128);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_idx", CW'(out_idx), CW'(2));
    rst = 1'b1;
    #1;
    chk("t6_abort_valid", CW'(out_valid), CW'(0));
    chk("t6_abort_data", out_data, CW'(0));
    chk("t6_abort_en", CW'(out_en), CW'(0));
    chk("t6_abort_idx", CW'(out_idx), CW'(0));
    chk("t6_abort_last", CW'(out_last), CW'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_src_ready", CW'(src_ready), CW'(1));
    rx_clear();
    send(one, all1, 128);
    drain();
    chk("t6_b0e0", CW'(rx_elem(0, 0)), CW'(0));
    chk("t6_b0e1", CW'(rx_elem(0, 1)), CW'(1));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
